// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and parameter checks for the 2x2 matmul datapath.
//   seq_state_t  - K-loop sequencer state encoding
//   *_DEF        - default operand/accumulator widths and maximum K depth
//   k_max_legal  - true when a K_MAX-deep sum of worst-case products fits ACC_W
package matmul_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 32;
    localparam int unsigned K_MAX_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_RESULT  = 3'd5
    } seq_state_t;

    // Largest magnitude product is (-2^(DATA_W-1))^2 = 2^(2*DATA_W-2); K_MAX of them must stay positive in ACC_W.
    function automatic bit k_max_legal(input int unsigned k_max,
                                       input int unsigned data_w,
                                       input int unsigned acc_w);
        longint unsigned worst;
        longint unsigned limit;
        worst = 64'(k_max) << (2 * data_w - 2);
        limit = (64'(1) << (acc_w - 1)) - 64'(1);
        return (k_max >= 1) && (worst <= limit);
    endfunction

endpackage

// File: rtl/matmul_k_sequencer.sv
// matmul_k_sequencer: sequences a K-deep operand stream onto mac_array_2x2
// and returns the accumulated 2x2 tile.
//   clk, rst_n          - clock, synchronous active-low reset
//   start, cfg_k        - job request and K depth (accepted only in IDLE)
//   busy, cfg_err       - job in flight / one-cycle pulse on a rejected start
//   in_valid/in_ready   - operand beat handshake: in_a = A column k, in_b = B row k
//   mac_clear, mac_en   - array control
//   mac_a, mac_b        - per-PE lane operands, mac_acc - array accumulators
//   res_valid/res_ready - result handshake, res_c = captured tile
module matmul_k_sequencer
    import matmul_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned ACC_W  = ACC_W_DEF,
    parameter  int unsigned K_MAX  = K_MAX_DEF,
    localparam int unsigned KW     = $clog2(K_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [KW-1:0]            cfg_k,
    output logic                     busy,
    output logic                     cfg_err,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a [2],
    input  logic signed [DATA_W-1:0] in_b [2],
    output logic                     mac_clear,
    output logic                     mac_en,
    output logic signed [DATA_W-1:0] mac_a [2][2],
    output logic signed [DATA_W-1:0] mac_b [2][2],
    input  logic signed [ACC_W-1:0]  mac_acc [2][2],
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_c [2][2]
);

    // Elaboration-time guard against accumulator overflow for the chosen depth.
    if (!k_max_legal(K_MAX, DATA_W, ACC_W)) begin : g_param_check
        $error("matmul_k_sequencer: K_MAX products do not fit in ACC_W");
    end

    seq_state_t              state_q, state_d;
    logic [KW-1:0]           k_len_q, k_len_d;
    logic [KW-1:0]           cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    in_ready_q, in_ready_d;
    logic                    mac_clear_q, mac_clear_d;
    logic                    mac_en_q, mac_en_d;
    logic                    res_valid_q, res_valid_d;
    logic signed [DATA_W-1:0] mac_a_q [2][2];
    logic signed [DATA_W-1:0] mac_a_d [2][2];
    logic signed [DATA_W-1:0] mac_b_q [2][2];
    logic signed [DATA_W-1:0] mac_b_d [2][2];
    logic signed [ACC_W-1:0]  res_c_q [2][2];
    logic signed [ACC_W-1:0]  res_c_d [2][2];

    logic cfg_ok;
    logic beat_acc;
    logic last_beat;

    assign cfg_ok    = (cfg_k != '0) && (cfg_k <= KW'(K_MAX));
    assign beat_acc  = (state_q == ST_STREAM) && in_valid && in_ready_q;
    assign last_beat = (KW'(cnt_q + KW'(1)) == k_len_q);

    // Next-state and next-output logic; every output is registered from its _d value.
    always_comb begin
        state_d   = state_q;
        k_len_d   = k_len_q;
        cnt_d     = cnt_q;
        mac_a_d   = mac_a_q;
        mac_b_d   = mac_b_q;
        res_c_d   = res_c_q;
        cfg_err_d = 1'b0;
        mac_en_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        k_len_d = cfg_k;
                        cnt_d   = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR:   state_d = ST_STREAM;
            ST_STREAM: begin
                if (beat_acc) begin
                    // Broadcast: row i of the array sees A[i][k], column j sees B[k][j].
                    for (int i = 0; i < 2; i++) begin
                        for (int j = 0; j < 2; j++) begin
                            mac_a_d[i][j] = in_a[i];
                            mac_b_d[i][j] = in_b[j];
                        end
                    end
                    mac_en_d = 1'b1;
                    cnt_d    = KW'(cnt_q + KW'(1));
                    if (last_beat) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN:   state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                res_c_d = mac_acc;
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase

        // Moore-style outputs registered off the next state so they align with it.
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_STREAM);
        mac_clear_d = (state_d == ST_CLEAR);
        res_valid_d = (state_d == ST_RESULT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            mac_clear_q <= 1'b0;
            mac_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    mac_a_q[i][j] <= '0;
                    mac_b_q[i][j] <= '0;
                    res_c_q[i][j] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            cfg_err_q   <= cfg_err_d;
            in_ready_q  <= in_ready_d;
            mac_clear_q <= mac_clear_d;
            mac_en_q    <= mac_en_d;
            res_valid_q <= res_valid_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_c_q     <= res_c_d;
        end
    end

    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;
    assign in_ready  = in_ready_q;
    assign mac_clear = mac_clear_q;
    assign mac_en    = mac_en_q;
    assign res_valid = res_valid_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_c     = res_c_q;

endmodule

// File: tb/tb_matmul_k_sequencer.sv
// tb_matmul_k_sequencer: directed bench for matmul_k_sequencer with a stand-in
// 2x2 MAC array, a cycle-timeline reference model and literal tile checks.
module tb_matmul_k_sequencer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned K_MAX  = 16;
    localparam int unsigned KW     = $clog2(K_MAX + 1);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic [KW-1:0]            cfg_k;
    logic                     busy, cfg_err;
    logic                     in_valid, in_ready;
    logic signed [DATA_W-1:0] in_a [2];
    logic signed [DATA_W-1:0] in_b [2];
    logic                     mac_clear, mac_en;
    logic signed [DATA_W-1:0] mac_a [2][2];
    logic signed [DATA_W-1:0] mac_b [2][2];
    logic signed [ACC_W-1:0]  mac_acc [2][2];
    logic                     res_valid, res_ready;
    logic signed [ACC_W-1:0]  res_c [2][2];

    matmul_k_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .K_MAX(K_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k),
        .busy(busy), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_clear(mac_clear), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
        .mac_acc(mac_acc),
        .res_valid(res_valid), .res_ready(res_ready), .res_c(res_c)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int en_cnt = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (mac_en === 1'b1) en_cnt++;

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Stand-in for mac_array_2x2: clear wins, otherwise accumulate the lane product.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (!rst_n || mac_clear) mac_acc[i][j] <= '0;
                else if (mac_en) mac_acc[i][j] <= mac_acc[i][j] + mac_a[i][j] * mac_b[i][j];
    end

    // Reference model: expectations for the next cycle derived from job timing rules.
    bit m_active = 0;
    int m_k = 0, m_beats = 0, t_start = 0, t_last = 0;
    int qa0 [16], qa1 [16], qb0 [16], qb1 [16];
    bit e_busy = 0, e_cfg_err = 0, e_in_ready = 0, e_clear = 0, e_en = 0, e_rv = 0;
    int e_ma [2] = '{0, 0};
    int e_mb [2] = '{0, 0};
    int e_c  [4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        bit acc_beat, hs, n_err_p, n_clr;
        if (chk_en) begin
            check("busy", busy, e_busy);
            check("cfg_err", cfg_err, e_cfg_err);
            check("in_ready", in_ready, e_in_ready);
            check("mac_clear", mac_clear, e_clear);
            check("mac_en", mac_en, e_en);
            check("res_valid", res_valid, e_rv);
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    check("mac_a", mac_a[i][j], e_ma[i]);
                    check("mac_b", mac_b[i][j], e_mb[j]);
                    check("res_c", res_c[i][j], e_c[2*i+j]);
                end
        end
        if (!rst_n) begin
            m_active = 0; e_busy = 0; e_cfg_err = 0; e_in_ready = 0;
            e_clear = 0; e_en = 0; e_rv = 0;
            e_ma = '{0, 0}; e_mb = '{0, 0}; e_c = '{0, 0, 0, 0};
        end else begin
            acc_beat = e_in_ready && (in_valid === 1'b1);
            hs       = e_rv && (res_ready === 1'b1);
            n_err_p  = !m_active && start && (int'(cfg_k) == 0 || int'(cfg_k) > K_MAX);
            n_clr    = !m_active && start && !(int'(cfg_k) == 0 || int'(cfg_k) > K_MAX);
            if (acc_beat) begin
                e_ma[0] = in_a[0]; e_ma[1] = in_a[1];
                e_mb[0] = in_b[0]; e_mb[1] = in_b[1];
                qa0[m_beats] = in_a[0]; qa1[m_beats] = in_a[1];
                qb0[m_beats] = in_b[0]; qb1[m_beats] = in_b[1];
                m_beats++;
                if (m_beats == m_k) t_last = cyc;
            end
            if (hs) m_active = 0;
            if (n_clr) begin
                m_active = 1; m_k = int'(cfg_k); m_beats = 0; t_start = cyc;
            end
            e_in_ready = m_active && (cyc + 1 >= t_start + 2) && (m_beats < m_k);
            e_rv       = m_active && (m_beats == m_k) && (cyc + 1 >= t_last + 3);
            if (e_rv && (cyc + 1 == t_last + 3)) begin
                e_c = '{0, 0, 0, 0};
                for (int k = 0; k < m_k; k++) begin
                    e_c[0] += qa0[k] * qb0[k];
                    e_c[1] += qa0[k] * qb1[k];
                    e_c[2] += qa1[k] * qb0[k];
                    e_c[3] += qa1[k] * qb1[k];
                end
            end
            e_busy = m_active; e_cfg_err = n_err_p; e_clear = n_clr; e_en = acc_beat;
        end
    end

    // Job data: beat b carries A column b (ja0, ja1) and B row b (jb0, jb1).
    int ja0 [16], ja1 [16], jb0 [16], jb1 [16];
    int t_s, dt;
    int snap [4];

    task automatic set_beat(input int b, input int a0, input int a1, input int b0, input int b1);
        ja0[b] = a0; ja1[b] = a1; jb0[b] = b0; jb1[b] = b1;
    endtask

    // Call just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input int a0, input int a1, input int b0, input int b1);
        bit r;
        int n;
        r = 0; n = 0;
        in_valid = 1'b1;
        in_a[0] = DATA_W'(a0); in_a[1] = DATA_W'(a1);
        in_b[0] = DATA_W'(b0); in_b[1] = DATA_W'(b1);
        while (!r && n < 40) begin
            @(negedge clk); r = (in_ready === 1'b1);
            @(posedge clk); #1; n++;
        end
        if (!r) check("beat_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int k, input int stall_at, input int stall_n, input int rr_delay);
        bit seen;
        seen = 0;
        res_ready = (rr_delay == 0);
        en_cnt = 0;
        start = 1'b1; cfg_k = KW'(k); t_s = cyc;
        @(posedge clk); #1; start = 1'b0;
        for (int b = 0; b < k; b++) begin
            if (b == stall_at) repeat (stall_n) begin @(posedge clk); #1; end
            send_beat(ja0[b], ja1[b], jb0[b], jb1[b]);
        end
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin seen = 1; break; end
        end
        if (!seen) begin
            check("res_timeout", 0, 1);
            return;
        end
        dt = cyc - t_s;
        for (int i = 0; i < 4; i++) snap[i] = res_c[i/2][i%2];
        for (int d = 0; d < rr_delay; d++) begin
            if (d > 0) @(negedge clk);
            check("bp_res_valid", res_valid, 1);
            check("bp_busy", busy, 1);
            check("bp_c00", res_c[0][0], 19); check("bp_c01", res_c[0][1], 22);
            check("bp_c10", res_c[1][0], 43); check("bp_c11", res_c[1][1], 50);
            @(posedge clk); #1;
            start = (d < rr_delay - 1); cfg_k = KW'(2);
        end
        res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
        @(negedge clk);
        check("busy_after_hs", busy, 0);
        check("rv_after_hs", res_valid, 0);
    endtask

    task automatic check_tile(input string tag, input int c00, input int c01, input int c10, input int c11);
        check({tag, "_c00"}, snap[0], c00); check({tag, "_c01"}, snap[1], c01);
        check({tag, "_c10"}, snap[2], c10); check({tag, "_c11"}, snap[3], c11);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_k = '0; in_valid = 1'b0; res_ready = 1'b0;
        in_a = '{8'sd0, 8'sd0}; in_b = '{8'sd0, 8'sd0};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0); check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        @(posedge clk); #1;

        // K=2, no stalls.
        set_beat(0, 1, 3, 5, 6); set_beat(1, 2, 4, 7, 8);
        run_job(2, -1, 0, 0);
        check_tile("k2", 19, 22, 43, 50);
        check("k2_latency", dt, 6); check("k2_en_cycles", en_cnt, 2);
        @(posedge clk); #1;

        // K=3 with two idle cycles before beat 2.
        set_beat(0, 1, 0, 1, 2); set_beat(1, -1, 3, 3, 4); set_beat(2, 2, -2, -1, 5);
        run_job(3, 1, 2, 0);
        check_tile("k3", -4, 8, 11, 2);
        check("k3_en_cycles", en_cnt, 3);
        @(posedge clk); #1;

        // Result back-pressure for 5 cycles with ignored start pulses.
        set_beat(0, 1, 3, 5, 6); set_beat(1, 2, 4, 7, 8);
        run_job(2, -1, 0, 5);
        check_tile("bp", 19, 22, 43, 50);
        @(posedge clk); #1;

        // Illegal depths.
        for (int t = 0; t < 2; t++) begin
            start = 1'b1; cfg_k = (t == 0) ? KW'(0) : KW'(17);
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            check("ill_cfg_err", cfg_err, 1); check("ill_clear", mac_clear, 0);
            check("ill_busy", busy, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("ill_cfg_err_drop", cfg_err, 0); check("ill_busy2", busy, 0);
            @(posedge clk); #1;
        end

        // Reset after one beat of a K=3 job.
        start = 1'b1; cfg_k = KW'(3);
        @(posedge clk); #1; start = 1'b0;
        send_beat(1, 2, 3, 4);
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("mr_busy", busy, 0); check("mr_in_ready", in_ready, 0);
        check("mr_mac_en", mac_en, 0); check("mr_mac_a", mac_a[1][0], 0);
        check("mr_mac_b", mac_b[0][1], 0); check("mr_res_c", res_c[0][0], 0);
        @(posedge clk); #1;

        set_beat(0, -128, 127, -128, -128);
        run_job(1, -1, 0, 0);
        check_tile("k1", 16384, 16384, -16256, -16256);
        check("k1_en_cycles", en_cnt, 1);
        @(posedge clk); #1;

        // Maximum depth with the most negative operand everywhere.
        for (int b = 0; b < 16; b++) set_beat(b, -128, -128, -128, -128);
        run_job(16, -1, 0, 0);
        check_tile("k16", 262144, 262144, 262144, 262144);
        check("k16_latency", dt, 20); check("k16_en_cycles", en_cnt, 16);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
